// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data load/store requesters.
// Latency: grant one cycle after a request is seen in IDLE; done one cycle after mem_done (min 3 cycles/access).
// Backpressure: requesters hold en/addr/size/wdata until done; one memory transaction outstanding at a time.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-low reset
//   i_*             - fetch requester: i_en/i_addr/i_size in, i_done/i_err/i_data out
//   d_*             - data requester: d_en/d_we/d_addr/d_size/d_wdata in, d_done/d_err/d_data out
//   mem_*           - memory side: mem_en/mem_we/mem_addr/mem_size/mem_wdata out, mem_done/mem_rdata in
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DATA_STREAK = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_size,
  output logic              i_done,
  output logic              i_err,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_en,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SW = $clog2(DATA_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_INST, OWN_DATA} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              cancel_q, cancel_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] i_data_q, i_data_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              d_err_q, d_err_d;

  logic owner_en;
  logic data_win;
  logic resp_ok;

  assign owner_en = (owner_q == OWN_DATA) ? d_en : i_en;
  // Data wins unless it has used up its streak while a fetch is waiting.
  assign data_win = d_en && !(i_en && (streak_q == SW'(DATA_STREAK)));
  // A requester that dropped en mid-transaction gets no done pulse.
  assign resp_ok  = (state_q == RESP) && !cancel_q;

  assign i_done    = resp_ok && (owner_q == OWN_INST);
  assign d_done    = resp_ok && (owner_q == OWN_DATA);
  assign i_data    = i_done ? rdata_q : i_data_q;
  assign i_err     = i_done ? err_q   : i_err_q;
  assign d_data    = d_done ? rdata_q : d_data_q;
  assign d_err     = d_done ? err_q   : d_err_q;

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_size  = mem_size_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    timer_d     = timer_q;
    cancel_d    = cancel_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_size_d  = mem_size_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    i_data_d    = i_data_q;
    i_err_d     = i_err_q;
    d_data_d    = d_data_q;
    d_err_d     = d_err_q;

    case (state_q)
      IDLE: begin
        if (d_en || i_en) begin
          state_d  = ISSUE;
          timer_d  = '0;
          cancel_d = 1'b0;
          if (data_win) begin
            owner_d     = OWN_DATA;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_size_d  = d_size;
            mem_wdata_d = d_wdata;
            // Streak only counts data grants that made a fetch wait.
            streak_d    = i_en ? streak_q + 1'b1 : '0;
          end else begin
            owner_d     = OWN_INST;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_size_d  = i_size;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end

      ISSUE: begin
        timer_d  = timer_q + 1'b1;
        cancel_d = cancel_q || !owner_en;
        if (mem_done) begin
          // Completion wins over expiry when both land in the same cycle.
          rdata_d = mem_we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT)) begin
          // Final ISSUE cycle is the (TIMEOUT+1)th, so the error done lands
          // TIMEOUT+1 cycles after mem_en rises.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
        if (i_done) begin
          i_data_d = rdata_q;
          i_err_d  = err_q;
        end
        if (d_done) begin
          d_data_d = rdata_q;
          d_err_d  = err_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_INST;
      streak_q    <= '0;
      timer_q     <= '0;
      cancel_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_size_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      i_data_q    <= '0;
      i_err_q     <= 1'b0;
      d_data_q    <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      timer_q     <= timer_d;
      cancel_q    <= cancel_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_size_q  <= mem_size_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      i_data_q    <= i_data_d;
      i_err_q     <= i_err_d;
      d_data_q    <= d_data_d;
      d_err_q     <= d_err_d;
    end
  end

endmodule
